// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Loadable down-counter with run/pause control, a one-cycle terminal-count
// strobe and optional auto-reload. Used as a programmable interval or timeout
// generator.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous, active-high reset
//   load_i       capture load_val_i into the reload register and the count
//   load_val_i   value to load (WIDTH bits, unsigned)
//   start_i      begin counting from IDLE, or resume from PAUSED
//   pause_i      freeze the countdown while running
//   reload_en_i  at terminal count, reload from the reload register instead
//                of stopping
//   count_o      current counter value (registered)
//   busy_o       high while running or paused (decoded from the state register)
//   done_o       one-cycle pulse at terminal count (registered)
//
// Per-edge priority is load > pause > start.
// -----------------------------------------------------------------------------
module countdown_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             start_i,
    input  logic             pause_i,
    input  logic             reload_en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load_i) begin
                // Load aborts any countdown silently; start/pause are ignored.
                reload_q <= load_val_i;
                count_q  <= load_val_i;
                state_q  <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        // A zero count has nothing to time, so start is ignored.
                        if (start_i && (count_q != ZERO)) begin
                            state_q <= RUN;
                        end
                    end
                    RUN: begin
                        if (pause_i) begin
                            state_q <= PAUSED;
                        end else if (count_q == ZERO) begin
                            // Not reachable in normal operation; recover quietly.
                            state_q <= IDLE;
                        end else if (count_q == ONE) begin
                            // Terminal count handled explicitly so the
                            // decrement below can never underflow.
                            done_q <= 1'b1;
                            if (reload_en_i) begin
                                count_q <= reload_q;
                            end else begin
                                count_q <= ZERO;
                                state_q <= IDLE;
                            end
                        end else begin
                            count_q <= count_q - ONE;
                        end
                    end
                    PAUSED: begin
                        if (start_i && !pause_i) begin
                            state_q <= RUN;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign count_o = count_q;
    assign busy_o  = (state_q == RUN) || (state_q == PAUSED);
    assign done_o  = done_q;

endmodule
